ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single frame-RAM port between three requesters:
//   - client 0: ADC capture writer
//   - client 1: pixel de-accumulation process FSM
//   - client 2: readout / serial dump
//  A client keeps the port for as long as it holds its request, so a multi-cycle
//  read-modify-write sequence is never interleaved with another client.
//  Requests are arbitrated round-robin. Read data is returned to the client that
//  issued the read.
// PARAMETERS
//  NB_ADC      12  RAM data width (ADC sample width)
//  NB_ADDR     10  RAM address width (576 pixels for a 24x24 array)
//  RD_LAT       1  RAM read latency in cycles (1..4)
//  MAX_HOLD     0  max cycles one grant may last; 0 = unlimited
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous, active-high reset
//  i_req        in   3            request, bit k = client k
//  o_gnt        out  3            one-hot grant, registered
//  i_addr       in   3*NB_ADDR    client k address at [k*NB_ADDR +: NB_ADDR]
//  i_we         in   3            write enable, bit k = client k
//  i_wdata      in   3*NB_ADC     client k write data at [k*NB_ADC +: NB_ADC]
//  o_rdata      out  NB_ADC       read data, broadcast to all clients
//  o_rvalid     out  3            one-hot read-data-valid, tagged to the issuer
//  o_ram_addr   out  NB_ADDR      RAM address
//  o_ram_we     out  1            RAM write strobe
//  o_ram_wdata  out  NB_ADC       RAM write data
//  i_ram_rdata  in   NB_ADC       RAM read data, valid RD_LAT cycles after the address
//  o_err        out  1            sticky error flag; cleared only by rst
// BEHAVIOUR
//  Reset values:
//   - o_gnt=0, o_rvalid=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_err=0.
//   - RR pointer = client 0; read tag pipeline flushed; hold counter = 0.
//   - rst mid-burst drops the grant at that edge. No o_rvalid is issued for reads in flight.
//  States:
//   - IDLE: o_gnt=0. On any i_req, grant the first requester at or after the RR pointer.
//     o_gnt rises one edge after i_req.
//   - OWN(k): o_gnt[k]=1 while i_req[k]=1.
//   - Exit from OWN(k) when i_req[k]=0 is sampled:
//     - If other requests are pending, grant passes directly to the next requester after k.
//       There is no idle gap.
//     - Otherwise return to IDLE.
//   - On every grant change the RR pointer moves to (k+1) mod 3.
//   - Priority order from pointer p is p, p+1, p+2 (mod 3).
//  RAM mux (combinational from the registered owner):
//   - o_ram_addr  = i_addr[owner].
//   - o_ram_wdata = i_wdata[owner].
//   - o_ram_we    = i_we[owner] & o_gnt[owner].
//   - With no owner: addr=0, wdata=0, we=0.
//  Reads:
//   - A granted cycle with i_we[owner]=0 is a read.
//   - The one-hot owner tag enters an RD_LAT-deep shift register.
//   - o_rvalid = tag at the pipeline output; o_rdata = i_ram_rdata.
//   - A read issued on the last granted cycle still returns to its issuer after handoff.
//  Ungranted writes:
//   - i_we[k]=1 while o_gnt[k]=0 never reaches the RAM and sets o_err.
//  Hold limit (MAX_HOLD>0):
//   - The hold counter counts granted cycles.
//   - When it reaches MAX_HOLD: force release, set o_err, advance the pointer.
//   - The forced client cannot regain the grant until it deasserts i_req for at least 1 cycle.
//  Handoff:
//   - A request that rises in the same cycle the owner releases is eligible at that edge.
//   - Two simultaneous new requests are resolved by the RR pointer.
// TESTING
//  T1:
//   - Stimulus: reset, then i_req=3'b010 at cycle 2.
//   - Expect: o_gnt=3'b010 at cycle 3; o_ram_addr follows client 1.
//  T2:
//   - Stimulus: i_req=3'b111 held; each owner drops its request after 4 granted cycles.
//   - Expect: grant order 0,1,2,0; no gap cycles between grants.
//  T3:
//   - Stimulus: RD_LAT=2; client 1 reads addr 5 (RAM holds 12'hABC), then releases;
//     client 2 is granted next.
//   - Expect: o_rvalid=3'b010 with o_rdata=12'hABC two cycles after the read.
//  T4:
//   - Stimulus: client 0 writes 12'h123 to addr 7 while ungranted.
//   - Expect: RAM unchanged; o_err=1.
//  T5:
//   - Stimulus: MAX_HOLD=8; client 2 holds i_req high for 20 cycles; client 0 also requests.
//   - Expect: forced release after 8 cycles; o_gnt=3'b001; o_err=1.
//  T6:
//   - Stimulus: rst asserted mid-burst with a read in flight.
//   - Expect: next cycle o_gnt=0, o_rvalid=0, o_err=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Purpose:
//   Shares one frame-RAM port between three clients:
//     client 0 = ADC capture writer
//     client 1 = pixel de-accumulation FSM
//     client 2 = readout / serial dump
//   A client keeps the port for as long as it holds its request, so a
//   multi-cycle read-modify-write sequence is never interleaved with another
//   client. Requests are arbitrated round-robin. Read data is tagged back to
//   the client that issued the read.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_req[2:0]   request, bit k = client k
//   o_gnt[2:0]   registered one-hot grant
//   i_addr       client k address at [k*NB_ADDR +: NB_ADDR]
//   i_we[2:0]    client k write enable
//   i_wdata      client k write data at [k*NB_ADC +: NB_ADC]
//   o_rdata      RAM read data, broadcast to every client
//   o_rvalid     one-hot read-data-valid, tagged to the issuer
//   o_ram_*      RAM address / write strobe / write data
//   i_ram_rdata  RAM read data, valid RD_LAT cycles after the address
//   o_err        sticky error (ungranted write or hold-limit expiry)
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int NB_ADC   = 12,
    parameter int NB_ADDR  = 10,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            i_req,
    output logic [2:0]            o_gnt,
    input  logic [3*NB_ADDR-1:0]  i_addr,
    input  logic [2:0]            i_we,
    input  logic [3*NB_ADC-1:0]   i_wdata,
    output logic [NB_ADC-1:0]     o_rdata,
    output logic [2:0]            o_rvalid,
    output logic [NB_ADDR-1:0]    o_ram_addr,
    output logic                  o_ram_we,
    output logic [NB_ADC-1:0]     o_ram_wdata,
    input  logic [NB_ADC-1:0]     i_ram_rdata,
    output logic                  o_err
);

    localparam int HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    // The one-hot grant register is the FSM state: 0 = IDLE, bit k = OWN(k).
    logic [2:0]            gnt_q, gnt_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [2:0]            blocked_q, blocked_d;   // force-released, waiting for req to drop
    logic                  err_q, err_d;
    logic [3*RD_LAT-1:0]   tag_q, tag_d;           // read-tag shift register, stage 0 in LSBs

    logic [2:0]            eligible;
    logic [2:0]            rd_tag;
    logic [NB_ADDR-1:0]    addr_m  [3];
    logic [NB_ADC-1:0]     wdata_m [3];

    // Highest-priority candidate starting at pointer p, then p+1, p+2 (mod 3).
    // The candidates are rotated so the pointer position sits at bit 0, a
    // fixed priority encoder picks, and the result is rotated back.
    function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] p);
        logic [2:0] r;
        logic [2:0] s;
        logic [2:0] sel;
        case (p)
            2'd1:    r = {cand[0], cand[2], cand[1]};
            2'd2:    r = {cand[1], cand[0], cand[2]};
            default: r = cand;
        endcase
        if (r[0])      s = 3'b001;
        else if (r[1]) s = 3'b010;
        else if (r[2]) s = 3'b100;
        else           s = 3'b000;
        case (p)
            2'd1:    sel = {s[1], s[0], s[2]};
            2'd2:    sel = {s[0], s[2], s[1]};
            default: sel = s;
        endcase
        return sel;
    endfunction

    // Pointer value that follows a one-hot owner.
    function automatic logic [1:0] ptr_after(input logic [2:0] oh);
        logic [1:0] p;
        case (oh)
            3'b001:  p = 2'd1;
            3'b010:  p = 2'd2;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            blocked_q <= '0;
            err_q     <= 1'b0;
            tag_q     <= '0;
        end else begin
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            blocked_q <= blocked_d;
            err_q     <= err_d;
            tag_q     <= tag_d;
        end
    end

    // ---------------- next-state logic ----------------
    assign eligible = i_req & ~blocked_q;

    always_comb begin
        logic owner_req;
        logic hold_expired;
        logic [2:0] cand;

        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        // A forced client is re-admitted once it has dropped its request.
        blocked_d = blocked_q & i_req;
        err_d     = err_q | (|(i_we & ~gnt_q));
        owner_req = |(gnt_q & i_req);
        cand      = '0;

        hold_expired = (MAX_HOLD > 0) && owner_req && (hold_q == HOLD_W'(HOLD_LAST));

        if (gnt_q == 3'b000) begin
            if (|eligible) begin
                gnt_d  = rr_pick(eligible, ptr_q);
                ptr_d  = ptr_after(gnt_d);
                hold_d = '0;
            end
        end else if (!owner_req || hold_expired) begin
            // Handoff: the releasing owner is excluded and the search starts
            // just after it, so there is no idle gap when others are waiting.
            cand   = eligible & ~gnt_q;
            gnt_d  = rr_pick(cand, ptr_after(gnt_q));
            ptr_d  = (gnt_d != 3'b000) ? ptr_after(gnt_d) : ptr_after(gnt_q);
            hold_d = '0;
            if (hold_expired) begin
                err_d     = 1'b1;
                blocked_d = blocked_d | gnt_q;
            end
        end else if (MAX_HOLD > 0) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // ---------------- read tag pipeline ----------------
    // A granted cycle without a write is a read; its owner tag travels
    // RD_LAT stages so the data returns to the issuer even after handoff.
    assign rd_tag = gnt_q & ~i_we;

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_first
                assign tag_d[2:0] = rd_tag;
            end else begin : g_rest
                assign tag_d[gi*3 +: 3] = tag_q[(gi-1)*3 +: 3];
            end
        end
    endgenerate

    // ---------------- RAM mux ----------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mux
            assign addr_m[gi]  = gnt_q[gi] ? i_addr[gi*NB_ADDR +: NB_ADDR] : '0;
            assign wdata_m[gi] = gnt_q[gi] ? i_wdata[gi*NB_ADC +: NB_ADC]  : '0;
        end
    endgenerate

    // ---------------- outputs ----------------
    always_comb begin
        o_gnt       = gnt_q;
        o_err       = err_q;
        o_ram_addr  = addr_m[0] | addr_m[1] | addr_m[2];
        o_ram_wdata = wdata_m[0] | wdata_m[1] | wdata_m[2];
        o_ram_we    = |(gnt_q & i_we);
        o_rvalid    = tag_q[(RD_LAT-1)*3 +: 3];
        o_rdata     = i_ram_rdata;
    end

endmodule
